// File: rtl/sled_pkg.sv
// sled_pkg: shared segment codes, FSM states and counter width for the LED scanner
package sled_pkg;
  typedef enum logic [1:0] {OFF, BLANK, SHOW} state_t;
  localparam int CNT_W = 20;
  localparam logic [7:0] SEG_CODE [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };
endpackage

// File: rtl/seg7_dec.sv
// seg7_dec: hex nibble to active-low g..a segment pattern
module seg7_dec
  import sled_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  assign seg = SEG_CODE[hex][6:0];
endmodule

// File: rtl/sled_scan_ctrl.sv
// sled_scan_ctrl: multiplexed 8-digit seven-segment scanner with dead time
module sled_scan_ctrl
  import sled_pkg::*;
#(
  parameter int CLK_DIV = 50000,
  parameter int DEAD    = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       wr_dp,
  input  logic [7:0] blank_mask,
  output logic [7:0] seg,
  output logic [7:0] dig,
  output logic       frame_start
);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(DEAD - 1);
  localparam state_t ENTRY = (DEAD == 0) ? SHOW : BLANK;
  logic [4:0] store [8];
  state_t state, state_n;
  logic [2:0] idx, idx_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [4:0] cur;
  logic [6:0] code;
  logic lit;
  // digit store: one {dp, nibble} entry written per strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) store <= '{default: '0};
    else if (wr_en) store[wr_addr] <= {wr_dp, wr_data};
  end
  // slot sequencing: BLANK for DEAD cycles, SHOW for CLK_DIV cycles, en low forces OFF
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt + 1'b1;
    if (!en) begin
      state_n = OFF;
      idx_n   = '0;
      cnt_n   = '0;
    end else begin
      case (state)
        OFF: begin
          state_n = ENTRY;
          idx_n   = '0;
          cnt_n   = '0;
        end
        BLANK: if (cnt == BLANK_LAST) begin
          state_n = SHOW;
          cnt_n   = '0;
        end
        SHOW: if (cnt == SHOW_LAST) begin
          state_n = ENTRY;
          idx_n   = idx + 1'b1;
          cnt_n   = '0;
        end
        default: begin
          state_n = OFF;
          idx_n   = '0;
          cnt_n   = '0;
        end
      endcase
    end
  end
  // outputs are computed from the next state so they line up with the state register
  assign cur = store[idx_n];
  assign lit = (state_n == SHOW) && !blank_mask[idx_n];
  seg7_dec u_dec (.hex(cur[3:0]), .seg(code));
  // state, counters and registered display outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= OFF;
      idx         <= '0;
      cnt         <= '0;
      dig         <= 8'hFF;
      seg         <= 8'hFF;
      frame_start <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      cnt         <= cnt_n;
      dig         <= lit ? ~(8'h01 << idx_n) : 8'hFF;
      seg         <= lit ? {~cur[4], code} : 8'hFF;
      frame_start <= (state_n == SHOW) && (idx_n == 3'd0) && (cnt_n == '0);
    end
  end
endmodule

// File: tb/tb_sled_scan_ctrl.sv
// tb_sled_scan_ctrl: directed table-driven checks of the LED scanner
module tb_sled_scan_ctrl;
  logic clk = 1'b0;
  logic rst_n, en, wr_en, wr_dp;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic [7:0] blank_mask;
  logic [7:0] seg0, dig0, seg1, dig1;
  logic fs0, fs1;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic [7:0] dig;
    logic [7:0] seg;
  } vec_t;
  vec_t tbl [8];

  always #5 clk = ~clk;

  sled_scan_ctrl #(.CLK_DIV(4), .DEAD(1)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_dp(wr_dp), .blank_mask(blank_mask),
    .seg(seg0), .dig(dig0), .frame_start(fs0)
  );

  sled_scan_ctrl #(.CLK_DIV(1), .DEAD(0)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_dp(wr_dp), .blank_mask(blank_mask),
    .seg(seg1), .dig(dig1), .frame_start(fs1)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [3:0] d, input logic p);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_dp = p;
    step();
    wr_en = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] mask);
    for (int d = 0; d < 8; d++) begin
      for (int k = 0; k < 4; k++) begin
        chk("frame_dig", dig0, mask[d] ? 8'hFF : tbl[d].dig);
        chk("frame_seg", seg0, mask[d] ? 8'hFF : tbl[d].seg);
        chk("frame_fs", {7'b0, fs0}, {7'b0, (d == 0 && k == 0)});
        step();
      end
      chk("dead_dig", dig0, 8'hFF);
      chk("dead_seg", seg0, 8'hFF);
      step();
    end
    chk("frame_period_fs", {7'b0, fs0}, 8'h01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic got;
    tbl[0] = '{8'hFE, 8'hC0}; tbl[1] = '{8'hFD, 8'hF9};
    tbl[2] = '{8'hFB, 8'hA4}; tbl[3] = '{8'hF7, 8'hB0};
    tbl[4] = '{8'hEF, 8'h99}; tbl[5] = '{8'hDF, 8'h92};
    tbl[6] = '{8'hBF, 8'h82}; tbl[7] = '{8'h7F, 8'hF8};
    rst_n = 1'b0; en = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    wr_dp = 1'b0; blank_mask = '0;
    step();
    chk("rst_dig", dig0, 8'hFF);
    chk("rst_seg", seg0, 8'hFF);
    chk("rst_fs", {7'b0, fs0}, 8'h00);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) wr(3'(i), 4'(i), 1'b0);
    en = 1'b1;
    step();
    chk("first_blank_dig", dig0, 8'hFF);
    step();
    run_frame(8'h00);
    // live write to the digit being shown
    repeat (15) step();
    chk("d3_dig", dig0, 8'hF7);
    chk("d3_seg", seg0, 8'hB0);
    wr(3'd3, 4'hA, 1'b1);
    step();
    chk("live_wr_seg", seg0, 8'h08);
    chk("live_wr_dig", dig0, 8'hF7);
    step();
    chk("live_wr_last_dig", dig0, 8'hF7);
    step();
    chk("live_wr_slot_end", dig0, 8'hFF);
    wr(3'd3, 4'h3, 1'b0);
    // blank mask over a whole frame
    blank_mask = 8'h05;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      step();
      got = fs0;
    end
    chk("sync_fs", {7'b0, got}, 8'h01);
    run_frame(8'h05);
    blank_mask = 8'h00;
    // en drop mid-slot and restart
    repeat (26) step();
    chk("d5_dig", dig0, 8'hDF);
    en = 1'b0;
    step();
    chk("en_off_dig", dig0, 8'hFF);
    chk("en_off_seg", seg0, 8'hFF);
    step();
    chk("en_off_hold", dig0, 8'hFF);
    en = 1'b1;
    step();
    chk("restart_blank", dig0, 8'hFF);
    chk("fast_d0_dig", dig1, 8'hFE);
    chk("fast_d0_fs", {7'b0, fs1}, 8'h01);
    step();
    chk("restart_dig", dig0, 8'hFE);
    chk("restart_seg", seg0, 8'hC0);
    chk("restart_fs", {7'b0, fs0}, 8'h01);
    chk("fast_d1_dig", dig1, 8'hFD);
    for (int i = 2; i <= 8; i++) begin
      step();
      chk("fast_dig", dig1, tbl[i % 8].dig);
      chk("fast_seg", seg1, tbl[i % 8].seg);
      chk("fast_fs", {7'b0, fs1}, {7'b0, (i == 8)});
    end
    chk("d1_before_rst", dig0, 8'hFD);
    // asynchronous reset mid-frame
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_dig", dig0, 8'hFF);
    chk("async_rst_seg", seg0, 8'hFF);
    chk("async_rst_dig1", dig1, 8'hFF);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_blank", dig0, 8'hFF);
    chk("post_rst_fast_dig", dig1, 8'hFE);
    step();
    chk("post_rst_dig", dig0, 8'hFE);
    chk("post_rst_seg", seg0, 8'hC0);
    chk("post_rst_fast_seg", seg1, 8'hC0);
    repeat (5) step();
    chk("post_rst_d1_dig", dig0, 8'hFD);
    chk("post_rst_d1_seg", seg0, 8'hC0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
